// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcode and load funct3 constants plus the basic
// register-index and machine-word types used by the writeback stage.
package riscv_pkg;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] xword_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // True for the load major opcode.
  function automatic logic is_load_op(input logic [6:0] opcode);
    return opcode == OP_LOAD;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register, decode, the EX forwarding mux
// and the writeback/register-file block. The slave side is the register file.
interface wb_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [6:0]       MEMWB_opcode_out;
  logic [2:0]       MEMWB_funct3_out;
  logic [XLEN-1:0]  MEMWB_data_addr_out;
  logic             MEMWB_register_write_valid_out;
  logic [4:0]       MEMWB_write_reg_out;
  logic [XLEN-1:0]  MEMWB_reg_write_data_out;
  logic [XLEN-1:0]  MEMWB_data_read;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             wb_fwd_valid;
  logic [4:0]       wb_fwd_reg;
  logic [XLEN-1:0]  wb_fwd_data;
  logic             load_err;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output MEMWB_opcode_out, MEMWB_funct3_out, MEMWB_data_addr_out,
           MEMWB_register_write_valid_out, MEMWB_write_reg_out,
           MEMWB_reg_write_data_out, MEMWB_data_read, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_fwd_valid, wb_fwd_reg, wb_fwd_data,
           load_err, retired_cnt
  );

  modport slave (
    input  MEMWB_opcode_out, MEMWB_funct3_out, MEMWB_data_addr_out,
           MEMWB_register_write_valid_out, MEMWB_write_reg_out,
           MEMWB_reg_write_data_out, MEMWB_data_read, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_fwd_valid, wb_fwd_reg, wb_fwd_data,
           load_err, retired_cnt
  );
endinterface

// File: rtl/load_align.sv
// Load data alignment: picks the addressed byte/half/word out of the raw
// little-endian memory word, sign/zero extends it, and flags misaligned
// accesses and funct3 values that are not a legal load size.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] off,
  input  xword_t     data_read,
  output xword_t     ldata,
  output logic       misalign,
  output logic       illegal
);

  logic [7:0]         byte_u;
  logic [15:0]        half_u;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  // Lane selection: byte lane = offset, half lane = upper/lower by off[1].
  always_comb begin
    byte_u  = data_read[{off, 3'b000} +: 8];
    half_u  = off[1] ? data_read[31:16] : data_read[15:0];
    byte_s  = signed'(byte_u);
    half_s  = signed'(half_u);
    byte_sx = byte_s;
    half_sx = half_s;
  end

  // Size/sign decode with alignment and legality checks.
  always_comb begin
    ldata    = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:  ldata = xword_t'(byte_sx);
      F3_LBU: ldata = {24'h0, byte_u};
      F3_LH: begin
        ldata    = xword_t'(half_sx);
        misalign = off[0];
      end
      F3_LHU: begin
        ldata    = {16'h0, half_u};
        misalign = off[0];
      end
      F3_LW: begin
        ldata    = data_read;
        misalign = (off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file (x0 reads as zero).
// Selects aligned load data or the ALU result, commits it on the clock edge,
// exposes the committing write as a forwarding tap, keeps a sticky load
// error flag and a count of committed writes.
// Build option WB_BYPASS_EN: when defined, a read of the register being
// written in the same cycle returns the new value (write-through); otherwise
// the old stored value is returned and the hazard unit must stall.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] retired;
  logic             err_flag;

  logic             is_load;
  xword_t           ldata;
  logic             misalign;
  logic             illegal;
  logic             load_fault;
  logic [XLEN-1:0]  wdata;
  reg_idx_t         rd;
  logic             we;

  load_align u_load_align (
    .funct3    (bus.MEMWB_funct3_out),
    .off       (bus.MEMWB_data_addr_out[1:0]),
    .data_read (bus.MEMWB_data_read),
    .ldata     (ldata),
    .misalign  (misalign),
    .illegal   (illegal)
  );

  // Writeback value select and write enable; a faulting load never writes.
  always_comb begin
    rd         = bus.MEMWB_write_reg_out;
    is_load    = is_load_op(bus.MEMWB_opcode_out);
    load_fault = is_load && (misalign || illegal);
    wdata      = is_load ? ldata : bus.MEMWB_reg_write_data_out;
    we         = bus.MEMWB_register_write_valid_out && (rd != '0) && !load_fault;
  end

  // Register array commit; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[rd] <= wdata;
    end
  end

  // Retired-write counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired <= '0;
    else if (we) retired <= retired + 1'b1;
  end

  // Sticky load error: set by any misaligned or illegal load, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_flag <= 1'b0;
    else if (load_fault) err_flag <= 1'b1;
  end

  // Decode read ports, with optional same-cycle write-through.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    bus.rs2_data = regs[bus.rs2_addr];
`ifdef WB_BYPASS_EN
    if (we && (bus.rs1_addr == rd)) bus.rs1_data = wdata;
    if (we && (bus.rs2_addr == rd)) bus.rs2_data = wdata;
`endif
    if (bus.rs1_addr == '0) bus.rs1_data = '0;
    if (bus.rs2_addr == '0) bus.rs2_data = '0;
  end

  // Forwarding tap and status outputs.
  always_comb begin
    bus.wb_fwd_valid = we;
    bus.wb_fwd_reg   = rd;
    bus.wb_fwd_data  = wdata;
    bus.load_err     = err_flag;
    bus.retired_cnt  = retired;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run against a behavioural register-file model.
module tb_wb_regfile;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] m_regs [32];
  logic        m_err;
  logic [31:0] m_cnt;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what writeback should do with the current bus inputs.
  function automatic void ref_wb(output bit we, output logic [31:0] val, output bit fault);
    int unsigned size;
    bit          sgn;
    int unsigned off;
    logic [31:0] raw;
    fault = 0;
    val   = bus.MEMWB_reg_write_data_out;
    if (bus.MEMWB_opcode_out == 7'b0000011) begin
      size = 0;
      sgn  = 0;
      case (bus.MEMWB_funct3_out)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: begin size = 4; sgn = 0; end
        3'd4: begin size = 1; sgn = 0; end
        3'd5: begin size = 2; sgn = 0; end
        default: size = 0;
      endcase
      off = bus.MEMWB_data_addr_out % 4;
      if (size == 0 || (off % size) != 0) begin
        fault = 1;
      end else begin
        raw = bus.MEMWB_data_read >> (8 * off);
        if (size == 1) begin
          val = raw & 32'hFF;
          if (sgn && val >= 32'h80) val = val | 32'hFFFFFF00;
        end else if (size == 2) begin
          val = raw & 32'hFFFF;
          if (sgn && val >= 32'h8000) val = val | 32'hFFFF0000;
        end else begin
          val = raw;
        end
      end
    end
    we = bus.MEMWB_register_write_valid_out && bus.MEMWB_write_reg_out != 0 && !fault;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    bit w; logic [31:0] v; bit f;
    if (a == 0) return 32'h0;
    ref_wb(w, v, f);
`ifdef WB_BYPASS_EN
    if (w && a == bus.MEMWB_write_reg_out) return v;
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_err = 0;
    m_cnt = 0;
  endtask

  // Clock one edge, update the model with whatever was committed.
  task automatic commit_cycle();
    bit w; logic [31:0] v; bit f;
    ref_wb(w, v, f);
    @(posedge clk);
    if (w) begin
      m_regs[bus.MEMWB_write_reg_out] = v;
      m_cnt = m_cnt + 1;
    end
    if (f) m_err = 1;
    #1;
  endtask

  task automatic set_bus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic valid, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] rdata);
    bus.MEMWB_opcode_out               = op;
    bus.MEMWB_funct3_out               = f3;
    bus.MEMWB_data_addr_out            = addr;
    bus.MEMWB_register_write_valid_out = valid;
    bus.MEMWB_write_reg_out            = rd;
    bus.MEMWB_reg_write_data_out       = wd;
    bus.MEMWB_data_read                = rdata;
  endtask

  task automatic set_idle();
    set_bus(OP_OP, 3'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = 5'(a);
      bus.rs2_addr = 5'(31 - a);
      #1;
      checks++;
      if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read x%0d: rs1=%h rs2=%h expected 00000000", a, bus.rs1_data, bus.rs2_data);
      end
    end
    checks++;
    if (bus.load_err !== 1'b0 || bus.retired_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: load_err=%b retired_cnt=%0d expected 0/0", bus.load_err, bus.retired_cnt);
    end
  endtask

  task automatic test_basic_write();
    set_bus(OP_OP, 3'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
    #1;
    checks++;
    if (bus.wb_fwd_valid !== 1'b1 || bus.wb_fwd_reg !== 5'd5 || bus.wb_fwd_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_fwd: valid=%b reg=%0d data=%h expected 1/5/deadbeef",
               bus.wb_fwd_valid, bus.wb_fwd_reg, bus.wb_fwd_data);
    end
    commit_cycle();
    set_idle();
    bus.rs1_addr = 5'd5;
    #1;
    checks++;
    if (bus.rs1_data !== 32'hDEADBEEF || bus.retired_cnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_write: rs1=%h cnt=%0d expected deadbeef/1", bus.rs1_data, bus.retired_cnt);
    end
  endtask

  task automatic test_load_align();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  offs [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps [8] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                              32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    for (int i = 0; i < 8; i++) begin
      set_bus(OP_LOAD, f3s[i], 32'h1000 + 32'(offs[i]), 1'b1, 5'(10 + i), 32'h5555AAAA, 32'h80FF7F01);
      #1;
      checks++;
      if (bus.wb_fwd_valid !== 1'b1 || bus.wb_fwd_data !== exps[i]) begin
        errors++;
        $display("FAIL load_fwd f3=%0d off=%0d: valid=%b data=%h expected 1/%h",
                 f3s[i], offs[i], bus.wb_fwd_valid, bus.wb_fwd_data, exps[i]);
      end
      commit_cycle();
      set_idle();
      bus.rs1_addr = 5'(10 + i);
      #1;
      checks++;
      if (bus.rs1_data !== exps[i]) begin
        errors++;
        $display("FAIL load_commit f3=%0d off=%0d: got %h expected %h", f3s[i], offs[i], bus.rs1_data, exps[i]);
      end
    end
    checks++;
    if (bus.retired_cnt !== m_cnt) begin
      errors++;
      $display("FAIL load_count: got %0d expected %0d", bus.retired_cnt, m_cnt);
    end
  endtask

  task automatic test_load_err();
    logic [31:0] cnt_before;
    set_bus(OP_OPIMM, 3'd0, 32'h0, 1'b1, 5'd7, 32'h00000777, 32'h0);
    commit_cycle();
    cnt_before = m_cnt;
    set_bus(OP_LOAD, F3_LW, 32'h2002, 1'b1, 5'd7, 32'h0, 32'hCAFEF00D);
    bus.rs1_addr = 5'd7;
    #1;
    checks++;
    if (bus.wb_fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fwd: valid=%b expected 0", bus.wb_fwd_valid);
    end
    commit_cycle();
    set_idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h00000777 || bus.load_err !== 1'b1 || bus.retired_cnt !== cnt_before) begin
      errors++;
      $display("FAIL misalign_lw: x7=%h err=%b cnt=%0d expected 00000777/1/%0d",
               bus.rs1_data, bus.load_err, bus.retired_cnt, cnt_before);
    end
    set_bus(OP_LOAD, 3'b011, 32'h2000, 1'b1, 5'd7, 32'h0, 32'h12345678);
    #1;
    checks++;
    if (bus.wb_fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_fwd: valid=%b expected 0", bus.wb_fwd_valid);
    end
    commit_cycle();
    set_bus(OP_OP, 3'd0, 32'h0, 1'b1, 5'd8, 32'h88, 32'h0);
    commit_cycle();
    set_idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h00000777 || bus.load_err !== 1'b1 || bus.retired_cnt !== cnt_before + 1) begin
      errors++;
      $display("FAIL illegal_load: x7=%h err=%b cnt=%0d expected 00000777/1/%0d",
               bus.rs1_data, bus.load_err, bus.retired_cnt, cnt_before + 1);
    end
  endtask

  task automatic test_x0();
    logic [31:0] cnt_before;
    cnt_before = m_cnt;
    set_bus(OP_OP, 3'd0, 32'h0, 1'b1, 5'd0, 32'h00001234, 32'h0);
    bus.rs1_addr = 5'd0;
    #1;
    checks++;
    if (bus.wb_fwd_valid !== 1'b0 || bus.rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_fwd: valid=%b rs1=%h expected 0/00000000", bus.wb_fwd_valid, bus.rs1_data);
    end
    commit_cycle();
    set_idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h0 || bus.retired_cnt !== cnt_before) begin
      errors++;
      $display("FAIL x0_write: x0=%h cnt=%0d expected 00000000/%0d", bus.rs1_data, bus.retired_cnt, cnt_before);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [5] = '{OP_LOAD, OP_OP, OP_OPIMM, OP_JAL, OP_LUI};
    bit w; logic [31:0] v; bit f;
    for (int n = 0; n < 300; n++) begin
      set_bus(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, $urandom);
      bus.rs1_addr = ($urandom_range(0, 3) == 0) ? bus.MEMWB_write_reg_out : 5'($urandom_range(0, 31));
      bus.rs2_addr = 5'($urandom_range(0, 31));
      #1;
      ref_wb(w, v, f);
      checks++;
      if (bus.wb_fwd_valid !== w || (w && (bus.wb_fwd_reg !== bus.MEMWB_write_reg_out || bus.wb_fwd_data !== v))) begin
        errors++;
        $display("FAIL rand_fwd #%0d: valid=%b data=%h expected %b/%h", n, bus.wb_fwd_valid, bus.wb_fwd_data, w, v);
      end
      checks++;
      if (bus.rs1_data !== ref_read(bus.rs1_addr) || bus.rs2_data !== ref_read(bus.rs2_addr)) begin
        errors++;
        $display("FAIL rand_read #%0d: rs1[%0d]=%h rs2[%0d]=%h expected %h/%h", n, bus.rs1_addr, bus.rs1_data,
                 bus.rs2_addr, bus.rs2_data, ref_read(bus.rs1_addr), ref_read(bus.rs2_addr));
      end
      checks++;
      if (bus.load_err !== m_err || bus.retired_cnt !== m_cnt) begin
        errors++;
        $display("FAIL rand_status #%0d: err=%b cnt=%0d expected %b/%0d", n, bus.load_err, bus.retired_cnt, m_err, m_cnt);
      end
      commit_cycle();
    end
  endtask

  task automatic test_bypass_reset();
    logic [31:0] expect_same;
    set_bus(OP_OP, 3'd0, 32'h0, 1'b1, 5'd9, 32'h11111111, 32'h0);
    commit_cycle();
    set_bus(OP_OP, 3'd0, 32'h0, 1'b1, 5'd9, 32'hA5A5A5A5, 32'h0);
    bus.rs2_addr = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    expect_same = 32'hA5A5A5A5;
`else
    expect_same = 32'h11111111;
`endif
    checks++;
    if (bus.rs2_data !== expect_same) begin
      errors++;
      $display("FAIL same_cycle_read: rs2=%h expected %h", bus.rs2_data, expect_same);
    end
    commit_cycle();
    set_idle();
    #1;
    checks++;
    if (bus.rs2_data !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL after_write: rs2=%h expected a5a5a5a5", bus.rs2_data);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.rs2_data !== 32'h0 || bus.load_err !== 1'b0 || bus.retired_cnt !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: x9=%h err=%b cnt=%0d expected 00000000/0/0",
               bus.rs2_data, bus.load_err, bus.retired_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_write();
    test_load_align();
    test_load_err();
    test_x0();
    test_random();
    test_bypass_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
